// File: rtl/stw_pkg.sv
// Types and helpers shared by the STW BIST sequencer: state encoding, vector-word field map, width helper.
package stw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ACCUM = 3'd4,
    ST_DONE  = 3'd5
  } stw_state_e;

  // Vector word is {op1, op2, add_op, expected}; field k sits at bits [k*W +: W].
  localparam int VEC_FIELDS = 4;
  localparam int FLD_OP1    = 3;
  localparam int FLD_OP2    = 2;
  localparam int FLD_ADD    = 1;
  localparam int FLD_EXP    = 0;

  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stw_popcount.sv
// Registered population count of an N-bit vector.
module stw_popcount
  import stw_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N-1:0]                 bits_i,
  output logic [clog2_safe(N+1)-1:0]   count_o
);

  localparam int CW = clog2_safe(N + 1);

  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;

  always_comb begin
    count_d = '0;
    for (int i = 0; i < N; i++) begin
      count_d = count_d + CW'(bits_i[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/stw_bist_sequencer.sv
// Steps the systolic array's STW self-test ports through a programmable vector list and
// accumulates a sticky per-PE fault map for the repair logic.
//
// state | meaning
// IDLE  | out of reset, no run yet; waits for bist_start
// LOAD  | operands of vec[idx] driven, test_load_en pulsed
// START | stw_start pulsed
// WAIT  | waiting for array complete, bounded by the timeout counter
// ACCUM | fold result into fault map, pick next vector or finish
// DONE  | results held; bist_start begins a new run
module stw_bist_sequencer
  import stw_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int WORD_SIZE   = 16,
  parameter int NUM_VECTORS = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   bist_start_i,
  input  logic [clog2_safe(NUM_VECTORS+1)-1:0]   vec_count_i,
  input  logic                                   vec_wr_en_i,
  input  logic [clog2_safe(NUM_VECTORS)-1:0]     vec_wr_addr_i,
  input  logic [VEC_FIELDS*WORD_SIZE-1:0]        vec_wr_data_i,
  output logic [WORD_SIZE-1:0]                   stw_mult_op1_o,
  output logic [WORD_SIZE-1:0]                   stw_mult_op2_o,
  output logic [WORD_SIZE-1:0]                   stw_add_op_o,
  output logic [WORD_SIZE-1:0]                   stw_expected_o,
  output logic                                   stw_test_load_en_o,
  output logic                                   stw_start_o,
  input  logic                                   stw_complete_i,
  input  logic [ROWS*COLS-1:0]                   stw_result_i,
  output logic                                   array_hold_o,
  output logic                                   bist_busy_o,
  output logic                                   bist_done_o,
  output logic                                   bist_pass_o,
  output logic                                   bist_timeout_o,
  output logic [ROWS*COLS-1:0]                   fault_map_o,
  output logic [clog2_safe(ROWS*COLS+1)-1:0]     fault_count_o
);

  localparam int NPE = ROWS * COLS;
  localparam int VW  = VEC_FIELDS * WORD_SIZE;
  localparam int VCW = clog2_safe(NUM_VECTORS + 1);
  localparam int VAW = clog2_safe(NUM_VECTORS);
  localparam int TCW = clog2_safe(TIMEOUT_CYC);

  stw_state_e     state_q;
  logic [VCW-1:0] n_q;
  logic [VAW-1:0] idx_q;
  logic [TCW-1:0] wait_q;
  logic [VW-1:0]  op_q;
  logic           load_en_q;
  logic           start_q;
  logic           done_q;
  logic           pass_q;
  logic           timeout_q;
  logic [NPE-1:0] fault_map_q;
  logic [NPE-1:0] fault_map_d;

  logic [VW-1:0]  vec_mem_q [NUM_VECTORS];

  logic           busy;
  logic           wr_ok;
  logic           run_kick;
  logic [VCW-1:0] n_sel;
  logic [VAW-1:0] idx_nxt;
  logic [VW-1:0]  first_vec;
  logic           last_vec;
  logic           wait_first;
  logic           wait_tc;

  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign run_kick = bist_start_i && !busy;
  assign wr_ok    = vec_wr_en_i && !busy && (int'(vec_wr_addr_i) < NUM_VECTORS);

  assign n_sel    = (vec_count_i > VCW'(NUM_VECTORS)) ? VCW'(NUM_VECTORS) : vec_count_i;
  assign idx_nxt  = idx_q + 1'b1;
  assign last_vec = (VCW'(idx_q) == (n_q - VCW'(1)));

  // A write landing on the same edge as bist_start must reach the first vector.
  assign first_vec = (wr_ok && (vec_wr_addr_i == '0)) ? vec_wr_data_i : vec_mem_q[0];

  // Wait timer counts down from TIMEOUT_CYC-1; the load value marks the first WAIT cycle.
  assign wait_first = (wait_q == TCW'(TIMEOUT_CYC - 1));
  assign wait_tc    = (wait_q == '0);

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      vec_mem_q[vec_wr_addr_i] <= vec_wr_data_i;
    end
  end

  always_comb begin
    fault_map_d = fault_map_q;
    if (rst_i || run_kick) begin
      fault_map_d = '0;
    end else if (state_q == ST_ACCUM) begin
      fault_map_d = fault_map_q | stw_result_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      wait_q      <= '0;
      op_q        <= '0;
      load_en_q   <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fault_map_q <= '0;
    end else begin
      fault_map_q <= fault_map_d;
      load_en_q   <= 1'b0;
      start_q     <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bist_start_i) begin
            n_q       <= n_sel;
            idx_q     <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            if (n_sel == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q   <= ST_LOAD;
              load_en_q <= 1'b1;
              op_q      <= first_vec;
            end
          end
        end
        ST_LOAD: begin
          state_q <= ST_START;
          start_q <= 1'b1;
        end
        ST_START: begin
          state_q <= ST_WAIT;
          wait_q  <= TCW'(TIMEOUT_CYC - 1);
        end
        ST_WAIT: begin
          if (stw_complete_i && !wait_first) begin
            state_q <= ST_ACCUM;
          end else if (wait_tc) begin
            state_q   <= ST_ACCUM;
            timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        ST_ACCUM: begin
          if (timeout_q || last_vec) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            pass_q  <= (fault_map_d == '0) && !timeout_q;
          end else begin
            state_q   <= ST_LOAD;
            idx_q     <= idx_nxt;
            load_en_q <= 1'b1;
            op_q      <= vec_mem_q[idx_nxt];
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Fed from the next-state map so the count is already final on the cycle bist_done rises.
  stw_popcount #(.N(NPE)) u_popcount (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bits_i  (fault_map_d),
    .count_o (fault_count_o)
  );

  assign stw_mult_op1_o     = op_q[FLD_OP1*WORD_SIZE +: WORD_SIZE];
  assign stw_mult_op2_o     = op_q[FLD_OP2*WORD_SIZE +: WORD_SIZE];
  assign stw_add_op_o       = op_q[FLD_ADD*WORD_SIZE +: WORD_SIZE];
  assign stw_expected_o     = op_q[FLD_EXP*WORD_SIZE +: WORD_SIZE];
  // Strobes drop in the same cycle reset is raised, not one cycle later.
  assign stw_test_load_en_o = load_en_q && !rst_i;
  assign stw_start_o        = start_q && !rst_i;
  assign array_hold_o       = busy;
  assign bist_busy_o        = busy;
  assign bist_done_o        = done_q;
  assign bist_pass_o        = pass_q;
  assign bist_timeout_o     = timeout_q;
  assign fault_map_o        = fault_map_q;

endmodule
